// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: shared types and encodings for the AXI4 SRAM slave.
//   - burst type and response encodings
//   - mem_ax_t: address-channel fields latched on an AW/AR handshake
//   - rd_ent_t: one buffered read beat
//   - state_e: slave FSM state, also exported for debug
package mem_axi_pkg;

  localparam int MEM_ID_W = 6;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // addr is advanced beat by beat, so it always holds the current beat address.
  typedef struct packed {
    logic [MEM_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } mem_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rd_ent_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD      = 2'd3
  } state_e;

endpackage

// File: rtl/mem_axi_sram_slave_if.sv
// mem_axi_sram_slave_if: AXI4 memory-port bundle (AW, W, B, AR, R).
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; the sender holds its payload stable
// and keeps valid high until that edge, and valid never waits on ready.
//   master modport: drives aw*/w*/ar* payload+valid, bready, rready
//   slave modport : drives awready, wready, arready, b*, r*
interface mem_axi_sram_slave_if #(
  parameter int ID_WIDTH = 6
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/mem_axi_burst_addr.sv
// mem_axi_burst_addr: combinational AXI4 next-beat address.
//   addr, size, len, burst : current beat address and burst attributes
//   next_addr              : address of the following beat
//   burst_illegal          : reserved burst type, or WRAP with len not 1/3/7/15
module mem_axi_burst_addr
  import mem_axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        burst_illegal
);
  logic [31:0] step;
  logic [31:0] wrap_mask;

  always_comb begin
    step          = 32'd1 << size;
    // Wrap boundary is the total burst size in bytes.
    wrap_mask     = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr     = addr;
    burst_illegal = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = addr + step;
      BURST_WRAP: begin
        next_addr     = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
        burst_illegal = !((len == 8'd1) || (len == 8'd3) ||
                          (len == 8'd7) || (len == 8'd15));
      end
      default:     burst_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mem_axi_sram_slave.sv
// mem_axi_sram_slave: AXI4 slave terminating the memory port on a
// single-port synchronous SRAM (read data returns one cycle after the strobe).
//   aclk, areset : clock, synchronous active-high reset
//   s            : AXI4 slave bundle (AW/W/B/AR/R)
//   sram_*       : SRAM strobe, byte write enables, word address, data
//   dbg_state    : current FSM state
// Reads stream through a 2-entry FIFO; the beat returning from the SRAM is
// presented directly on R when the FIFO is empty, giving one beat per cycle.
module mem_axi_sram_slave
  import mem_axi_pkg::*;
#(
  parameter int  ID_WIDTH  = MEM_ID_W,
  parameter int  MEM_WORDS = 65536,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  aclk,
  input  logic                  areset,
  mem_axi_sram_slave_if.slave   s,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [AW-1:0]         sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output state_e                dbg_state
);
  state_e             state_q, state_d;
  mem_ax_t            ax_q, ax_d;
  logic [8:0]         cnt_q, cnt_d;         // write beats done / read beats issued
  logic               err_q, err_d;         // sticky write error
  logic               rd_pref_q, rd_pref_d; // arbitration favours read when set
  logic               pend_q, pend_d;       // SRAM read returns this cycle
  logic               pend_err_q, pend_err_d;
  logic               pend_last_q, pend_last_d;
  rd_ent_t [1:0]      fifo_q, fifo_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         fcnt_q, fcnt_d;

  logic [31:0]        next_addr;
  logic               burst_illegal, beat_err, is_last;
  logic               grant_w, grant_r, issue, push, pop, rvalid_c;
  logic               sram_en_c;
  logic [3:0]         sram_we_c;
  rd_ent_t            byp, r_ent;

  mem_axi_burst_addr u_addr (
    .addr          (ax_q.addr),
    .size          (ax_q.size),
    .len           (ax_q.len),
    .burst         (ax_q.burst),
    .next_addr     (next_addr),
    .burst_illegal (burst_illegal)
  );

  assign beat_err = burst_illegal || ({2'b00, ax_q.addr[31:2]} >= 32'(MEM_WORDS));
  assign is_last  = (cnt_q == {1'b0, ax_q.len});

  // R channel source: FIFO head, else the beat arriving from the SRAM.
  assign byp.data = pend_err_q ? 32'd0 : sram_rdata;
  assign byp.resp = pend_err_q ? RESP_SLVERR : RESP_OKAY;
  assign byp.last = pend_last_q;
  assign r_ent    = (fcnt_q != 2'd0) ? fifo_q[rd_ptr_q] : byp;
  assign rvalid_c = (fcnt_q != 2'd0) || pend_q;

  assign s.rvalid  = rvalid_c;
  assign s.rdata   = rvalid_c ? r_ent.data : 32'd0;
  assign s.rresp   = rvalid_c ? r_ent.resp : RESP_OKAY;
  assign s.rlast   = rvalid_c && r_ent.last;
  assign s.rid     = ID_WIDTH'(ax_q.id);
  assign s.bid     = ID_WIDTH'(ax_q.id);
  assign s.bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign sram_addr = ax_q.addr[AW+1:2];
  assign sram_en   = sram_en_c && !areset;
  assign sram_we   = areset ? 4'h0 : sram_we_c;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    ax_d        = ax_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rd_pref_d   = rd_pref_q;
    pend_d      = 1'b0;
    pend_err_d  = pend_err_q;
    pend_last_d = pend_last_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q;
    grant_w     = 1'b0;
    grant_r     = 1'b0;
    issue       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    s.awready   = 1'b0;
    s.arready   = 1'b0;
    s.wready    = 1'b0;
    s.bvalid    = 1'b0;
    sram_en_c   = 1'b0;
    sram_we_c   = 4'h0;
    sram_wdata  = 32'd0;

    case (state_q)
      IDLE: begin
        grant_w   = s.awvalid && (!s.arvalid || !rd_pref_q);
        grant_r   = s.arvalid && !grant_w;
        s.awready = grant_w;
        s.arready = grant_r;
        cnt_d     = 9'd0;
        err_d     = 1'b0;
        if (grant_w) begin
          ax_d      = '{id: MEM_ID_W'(s.awid), addr: s.awaddr, len: s.awlen,
                        size: s.awsize, burst: s.awburst};
          rd_pref_d = !rd_pref_q;
          state_d   = WR_DATA;
        end else if (grant_r) begin
          ax_d      = '{id: MEM_ID_W'(s.arid), addr: s.araddr, len: s.arlen,
                        size: s.arsize, burst: s.arburst};
          rd_pref_d = !rd_pref_q;
          state_d   = RD;
        end
      end
      WR_DATA: begin
        s.wready = 1'b1;
        if (s.wvalid) begin
          sram_en_c  = !beat_err;
          sram_we_c  = beat_err ? 4'h0 : s.wstrb;
          sram_wdata = s.wdata;
          // The counter ends the burst; a misplaced wlast only marks the error.
          if (beat_err || (s.wlast != is_last)) err_d = 1'b1;
          ax_d.addr = next_addr;
          cnt_d     = cnt_q + 9'd1;
          if (is_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        s.bvalid = 1'b1;
        if (s.bready) state_d = IDLE;
      end
      RD: begin
        // Outstanding beats (buffered + in flight) never exceed FIFO depth.
        issue = (cnt_q <= {1'b0, ax_q.len}) && ((fcnt_q + {1'b0, pend_q}) < 2'd2);
        if (issue) begin
          sram_en_c   = !beat_err;
          pend_d      = 1'b1;
          pend_err_d  = beat_err;
          pend_last_d = is_last;
          ax_d.addr   = next_addr;
          cnt_d       = cnt_q + 9'd1;
        end
        pop  = rvalid_c && s.rready && (fcnt_q != 2'd0);
        push = pend_q && !((fcnt_q == 2'd0) && s.rready);
        if (push) begin
          fifo_d[wr_ptr_q] = byp;
          wr_ptr_d         = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        fcnt_d = fcnt_q + 2'(push) - 2'(pop);
        if (rvalid_c && s.rready && r_ent.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      ax_q        <= '0;
      cnt_q       <= 9'd0;
      err_q       <= 1'b0;
      rd_pref_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_last_q <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      ax_q        <= ax_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rd_pref_q   <= rd_pref_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      pend_last_q <= pend_last_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_mem_axi_sram_slave.sv
// tb_mem_axi_sram_slave: directed bench for mem_axi_sram_slave with a
// behavioural SRAM; table of single-beat write/read-back vectors plus
// hand-written burst, backpressure, arbitration and reset sequences.
module tb_mem_axi_sram_slave;
  import mem_axi_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           sram_en;
  logic [3:0]     sram_we;
  logic [AW-1:0]  sram_addr;
  logic [31:0]    sram_wdata;
  logic [31:0]    sram_rdata = 32'd0;
  state_e         dbg_state;

  mem_axi_sram_slave_if #(.ID_WIDTH(6)) bus ();

  mem_axi_sram_slave #(.ID_WIDTH(6), .MEM_WORDS(MEM_WORDS)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s          (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- SRAM model ----------------
  logic [31:0] mem [MEM_WORDS];
  int sram_wr_cnt = 0;
  int sram_rd_cnt = 0;

  initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;

  always @(posedge aclk) begin
    if (sram_en) begin
      if (sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        sram_rdata  <= mem[sram_addr];
        sram_rd_cnt <= sram_rd_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  int          n_beats, first_c, done_c;

  task automatic bus_idle();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
    bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int bad_last_at, output logic [1:0] resp);
    int t;
    @(posedge aclk); #1;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!bus.awready && t < 20) begin @(negedge aclk); t++; end
    chk("aw_accept", 32'(bus.awready), 32'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wd[i]; bus.wstrb = ws[i];
      bus.wlast = (i == int'(len)) ^ (i == bad_last_at);
      bus.wvalid = 1'b1;
      @(negedge aclk);
      chk("wready", 32'(bus.wready), 32'd1);
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge aclk);
    chk("bvalid_after_last_w", 32'(bus.bvalid), 32'd1);
    chk("bid", 32'(bus.bid), 32'(id));
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  function automatic logic rr_pat(input int mode, input int c);
    return (mode == 0) ? 1'b1 : ((c % 3) == 1);
  endfunction

  task automatic axi_read(input logic [5:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int mode);
    int t, issued0, delivered;
    logic done, stalled, p_l;
    logic [31:0] p_d;
    logic [1:0] p_r;
    n_beats = 0; first_c = -1; done_c = -1; done = 1'b0; stalled = 1'b0;
    p_d = '0; p_r = '0; p_l = 1'b0; delivered = 0;
    @(posedge aclk); #1;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
    bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!bus.arready && t < 20) begin @(negedge aclk); t++; end
    chk("ar_accept", 32'(bus.arready), 32'd1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    issued0 = sram_rd_cnt;
    bus.rready = rr_pat(mode, 1);
    for (int c = 1; c < 100 && !done; c++) begin
      @(negedge aclk);
      if (stalled) begin
        chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
        chk("r_hold_data", bus.rdata, p_d);
        chk("r_hold_resp", 32'(bus.rresp), 32'(p_r));
        chk("r_hold_last", 32'(bus.rlast), 32'(p_l));
      end
      if (sram_en && sram_we == 4'h0)
        chk("r_issue_room", 32'((sram_rd_cnt - issued0 - delivered) < 2), 32'd1);
      if (bus.rvalid) begin
        if (first_c < 0) first_c = c;
        if (bus.rready) begin
          chk("rid", 32'(bus.rid), 32'(id));
          if (n_beats < 16) begin
            rd_d[n_beats] = bus.rdata; rd_r[n_beats] = bus.rresp; rd_l[n_beats] = bus.rlast;
          end
          n_beats++; delivered++;
          if (bus.rlast) begin done = 1'b1; done_c = c; end
        end
      end
      stalled = bus.rvalid && !bus.rready;
      p_d = bus.rdata; p_r = bus.rresp; p_l = bus.rlast;
      @(posedge aclk); #1;
      bus.rready = rr_pat(mode, c + 1);
    end
    bus.rready = 1'b0;
    chk("r_done", 32'(done), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_b;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rr;
    int          exp_wr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int w0;

    vecs[0] = '{32'h040, BURST_INCR,  32'hFFFFFFFF, 4'hF, RESP_OKAY,   32'hFFFFFFFF, RESP_OKAY,   1};
    vecs[1] = '{32'h040, BURST_INCR,  32'h11223344, 4'h5, RESP_OKAY,   32'hFF22FF44, RESP_OKAY,   1};
    vecs[2] = '{32'h044, BURST_FIXED, 32'h12345678, 4'hF, RESP_OKAY,   32'h12345678, RESP_OKAY,   1};
    vecs[3] = '{32'h048, BURST_INCR,  32'hAABBCCDD, 4'h8, RESP_OKAY,   32'hAA000000, RESP_OKAY,   1};
    vecs[4] = '{32'h1000, BURST_INCR, 32'hDEADBEEF, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 0};
    vecs[5] = '{32'hFFC, BURST_INCR,  32'hCAFEF00D, 4'hF, RESP_OKAY,   32'hCAFEF00D, RESP_OKAY,   1};
    vecs[6] = '{32'h050, BURST_WRAP,  32'h55555555, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 0};
    vecs[7] = '{32'h054, 2'b11,       32'h66666666, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 0};
    vecs[8] = '{32'h04C, BURST_INCR,  32'h12345677, 4'h1, RESP_OKAY,   32'h00000077, RESP_OKAY,   1};

    bus_idle();
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // ---- reset state ----
    @(negedge aclk);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_sram_en", 32'(sram_en),     32'd0);
    chk("rst_sram_we", 32'(sram_we),     32'd0);
    chk("rst_state",   32'(dbg_state),   32'(IDLE));

    // ---- arbitration: AW and AR together after reset -> write first ----
    @(posedge aclk); #1;
    bus.awid = 6'd3; bus.awaddr = 32'h080; bus.awlen = 8'd0; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    bus.arid = 6'd4; bus.araddr = 32'h080; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    @(negedge aclk);
    chk("arb_awready", 32'(bus.awready), 32'd1);
    chk("arb_arready", 32'(bus.arready), 32'd0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    @(negedge aclk);
    chk("arb_wready", 32'(bus.wready), 32'd1);
    chk("arb_ar_blocked", 32'(bus.arready), 32'd0);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    @(negedge aclk);
    chk("arb_bvalid", 32'(bus.bvalid), 32'd1);
    chk("arb_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    @(negedge aclk);
    chk("arb_arready_next", 32'(bus.arready), 32'd1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge aclk);
    chk("arb_rvalid_n1", 32'(bus.rvalid), 32'd0);
    @(negedge aclk);
    chk("arb_rvalid_n2", 32'(bus.rvalid), 32'd1);
    chk("arb_rdata", bus.rdata, 32'h0BADF00D);
    chk("arb_rlast", 32'(bus.rlast), 32'd1);
    chk("arb_rid", 32'(bus.rid), 32'd4);
    @(posedge aclk); #1;
    bus.rready = 1'b0;

    // ---- table: single-beat write then read back ----
    for (int i = 0; i < 9; i++) begin
      wd[0] = vecs[i].wdata; ws[0] = vecs[i].wstrb;
      w0 = sram_wr_cnt;
      axi_write(6'(i), vecs[i].addr, 8'd0, vecs[i].burst, -1, resp);
      chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_b));
      chk($sformatf("vec%0d_sram_writes", i), 32'(sram_wr_cnt - w0), 32'(vecs[i].exp_wr));
      axi_read(6'(i + 16), vecs[i].addr, 8'd0, vecs[i].burst, 0);
      chk($sformatf("vec%0d_beats", i), 32'(n_beats), 32'd1);
      chk($sformatf("vec%0d_rdata", i), rd_d[0], vecs[i].exp_rd);
      chk($sformatf("vec%0d_rresp", i), 32'(rd_r[0]), 32'(vecs[i].exp_rr));
    end

    // ---- INCR write + read, 4 beats ----
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    axi_write(6'd5, 32'h100, 8'd3, BURST_INCR, -1, resp);
    chk("incr_bresp", 32'(resp), 32'(RESP_OKAY));
    axi_read(6'd6, 32'h100, 8'd3, BURST_INCR, 0);
    chk("incr_beats", 32'(n_beats), 32'd4);
    chk("incr_first_rvalid", 32'(first_c), 32'd2);
    chk("incr_done_cycle", 32'(done_c), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rd_d[i], 32'hA0 + 32'(i));
      chk($sformatf("incr_rlast%0d", i), 32'(rd_l[i]), 32'(i == 3));
    end

    // ---- WRAP read: 0x108,0x10C,0x100,0x104 ----
    axi_read(6'd7, 32'h108, 8'd3, BURST_WRAP, 0);
    chk("wrap_beats", 32'(n_beats), 32'd4);
    chk("wrap_rdata0", rd_d[0], 32'hA2);
    chk("wrap_rdata1", rd_d[1], 32'hA3);
    chk("wrap_rdata2", rd_d[2], 32'hA0);
    chk("wrap_rdata3", rd_d[3], 32'hA1);
    chk("wrap_rresp", 32'(rd_r[3]), 32'(RESP_OKAY));

    // ---- early wlast: error flagged, counter still runs both beats ----
    wd[0] = 32'h1111; wd[1] = 32'h2222; ws[0] = 4'hF; ws[1] = 4'hF;
    w0 = sram_wr_cnt;
    axi_write(6'd8, 32'h180, 8'd1, BURST_INCR, 0, resp);
    chk("wlast_bresp", 32'(resp), 32'(RESP_SLVERR));
    chk("wlast_writes", 32'(sram_wr_cnt - w0), 32'd2);
    chk("wlast_mem1", mem[32'h184 >> 2], 32'h2222);

    // ---- backpressure: 8-beat read, rready 1,0,0,... ----
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    axi_write(6'd9, 32'h200, 8'd7, BURST_INCR, -1, resp);
    chk("bp_bresp", 32'(resp), 32'(RESP_OKAY));
    axi_read(6'd10, 32'h200, 8'd7, BURST_INCR, 1);
    chk("bp_beats", 32'(n_beats), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_rdata%0d", i), rd_d[i], 32'hB0 + 32'(i));
      chk($sformatf("bp_rlast%0d", i), 32'(rd_l[i]), 32'(i == 7));
    end

    // ---- reserved burst read, len 1: two zero SLVERR beats ----
    axi_read(6'd11, 32'h100, 8'd1, 2'b11, 0);
    chk("rsv_beats", 32'(n_beats), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsv_rdata%0d", i), rd_d[i], 32'd0);
      chk($sformatf("rsv_rresp%0d", i), 32'(rd_r[i]), 32'(RESP_SLVERR));
      chk($sformatf("rsv_rlast%0d", i), 32'(rd_l[i]), 32'(i == 1));
    end

    // ---- reset at second beat of a 4-beat write ----
    @(posedge aclk); #1;
    bus.awid = 6'd12; bus.awaddr = 32'h300; bus.awlen = 8'd3; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    @(negedge aclk);
    chk("rstw_awready", 32'(bus.awready), 32'd1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = 32'hC0; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    @(posedge aclk); #1;
    bus.wdata = 32'hC1; areset = 1'b1;
    @(negedge aclk);
    chk("rstw_sram_we", 32'(sram_we), 32'd0);
    chk("rstw_sram_en", 32'(sram_en), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0; bus.wvalid = 1'b0;
    @(negedge aclk);
    chk("rstw_state", 32'(dbg_state), 32'(IDLE));
    chk("rstw_wready", 32'(bus.wready), 32'd0);
    chk("rstw_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rstw_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rstw_awready_idle", 32'(bus.awready), 32'd0);
    chk("rstw_sram_en_after", 32'(sram_en), 32'd0);
    chk("rstw_bresp", 32'(bus.bresp), 32'd0);
    chk("rstw_mem0", mem[32'h300 >> 2], 32'hC0);
    chk("rstw_mem1", mem[32'h304 >> 2], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
